// File: rtl/spinex_reset_ctrl.sv
// spinex_reset_ctrl: reset front-end for the SoC core.
// Synchronises and debounces the active-low devboard button.
// Generates a stretched, staggered reset pair: periph_reset is released first,
// then sys_reset is released STAGGER_CYCLES later.
// Records the cause of the last reset.
// Optional watchdog: define SPINEX_RST_WDT_EN to enable it.
// wdt_kick clears the watchdog counter. A timeout forces HOLD with cause 10.
module spinex_reset_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGGER_CYCLES  = 16,
    parameter int WDT_TIMEOUT     = 24000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_n,
    input  logic       wdt_kick,
    output logic       periph_reset,
    output logic       sys_reset,
    output logic       running,
    output logic [1:0] reset_cause
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int STAG_W = (STAGGER_CYCLES > 1)  ? $clog2(STAGGER_CYCLES)  : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_WDT    = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_PREL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_r;
    logic              sync1_r;
    logic              sync2_r;
    logic              deb_r;        // accepted button level, 1 = released
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [STAG_W-1:0] stag_cnt_r;
    logic              deb_flip_s;
    logic              press_s;
    logic              wdt_fire_s;

    // Two-flop synchroniser; the button idles high (released) out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= button_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a level change only after the terminal count of consecutive mismatches
    always_comb begin
        deb_flip_s = 1'b0;
        if ((sync2_r != deb_r) && (deb_cnt_r == DEB_LAST)) begin
            deb_flip_s = 1'b1;
        end else begin
            deb_flip_s = 1'b0;
        end
    end

    // A press is the accepted level moving from released to pressed
    assign press_s = deb_flip_s & deb_r;

    // Debounce counter and accepted level; any agreeing sample restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r     <= 1'b1;
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (deb_flip_s) begin
            deb_r     <= ~deb_r;
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (sync2_r != deb_r) begin
            deb_cnt_r <= deb_cnt_r + DEB_W'(1'b1);
        end else begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end
    end

`ifdef SPINEX_RST_WDT_EN
    localparam int WDT_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_cnt_r;

    // Timeout fires at the terminal count unless a kick arrives in the same cycle
    always_comb begin
        wdt_fire_s = 1'b0;
        if ((state_r == ST_RUN) && !wdt_kick && (wdt_cnt_r == WDT_LAST)) begin
            wdt_fire_s = 1'b1;
        end else begin
            wdt_fire_s = 1'b0;
        end
    end

    // Watchdog counts only in RUN; kicks, timeouts and presses restart it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt_r <= {WDT_W{1'b0}};
        end else if ((state_r != ST_RUN) || wdt_kick || press_s || wdt_fire_s) begin
            wdt_cnt_r <= {WDT_W{1'b0}};
        end else begin
            wdt_cnt_r <= wdt_cnt_r + WDT_W'(1'b1);
        end
    end
`else
    logic unused_kick_s;

    assign unused_kick_s = wdt_kick;
    assign wdt_fire_s    = 1'b0;
`endif

    // Reset sequencer: HOLD stretches the reset, PREL staggers it, RUN waits for an event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            stag_cnt_r  <= {STAG_W{1'b0}};
            reset_cause <= CAUSE_POR;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (press_s) begin
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        reset_cause <= CAUSE_BUTTON;
                    end else if (deb_r == 1'b0) begin
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r <= {HOLD_W{1'b0}};
                        state_r    <= ST_PREL;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
                    end
                end
                ST_PREL: begin
                    if (press_s) begin
                        state_r     <= ST_HOLD;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        stag_cnt_r  <= {STAG_W{1'b0}};
                        reset_cause <= CAUSE_BUTTON;
                    end else if (stag_cnt_r == STAG_LAST) begin
                        stag_cnt_r <= {STAG_W{1'b0}};
                        state_r    <= ST_RUN;
                    end else begin
                        stag_cnt_r <= stag_cnt_r + STAG_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    if (press_s) begin
                        state_r     <= ST_HOLD;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        stag_cnt_r  <= {STAG_W{1'b0}};
                        reset_cause <= CAUSE_BUTTON;
                    end else if (wdt_fire_s) begin
                        state_r     <= ST_HOLD;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        stag_cnt_r  <= {STAG_W{1'b0}};
                        reset_cause <= CAUSE_WDT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_HOLD;
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    stag_cnt_r <= {STAG_W{1'b0}};
                end
            endcase
        end
    end

    // Registered reset outputs decoded from the sequencer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periph_reset <= 1'b1;
            sys_reset    <= 1'b1;
            running      <= 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    periph_reset <= 1'b1;
                    sys_reset    <= 1'b1;
                    running      <= 1'b0;
                end
                ST_PREL: begin
                    periph_reset <= 1'b0;
                    sys_reset    <= 1'b1;
                    running      <= 1'b0;
                end
                ST_RUN: begin
                    periph_reset <= 1'b0;
                    sys_reset    <= 1'b0;
                    running      <= 1'b1;
                end
                default: begin
                    periph_reset <= 1'b1;
                    sys_reset    <= 1'b1;
                    running      <= 1'b0;
                end
            endcase
        end
    end

endmodule
